// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID opcode, carries control through ID/EX, EX/MEM, MEM/WB,
// stalls on load-use and flushes after taken branches. PIPE_CTRL_PERF_CNT_EN enables stall/flush counters.
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int ALU_OP_W    = 2,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [6:0]            opcode,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  ex_taken,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic [ALU_OP_W-1:0]   ex_alu_op,
    output logic                  ex_alu_src,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_mem_2_reg,
    output logic                  wb_reg_write,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
);

    // state    | meaning
    // ST_RUN   | normal issue; a taken branch in EX flushes IF/ID this cycle
    // ST_FLUSH | extra bubbles after a taken branch, flush_left_q cycles remain
    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_RTYPE = ALU_OP_W'(2);
    localparam logic [1:0]          FLUSH_INIT = 2'(FLUSH_DEPTH - 1);

    typedef struct packed {
        logic [ALU_OP_W-1:0]   alu_op;
        logic                  alu_src;
        logic                  branch;
        logic                  jump;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_2_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_2_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic                  mem_2_reg;
        logic                  reg_write;
        logic [REG_ADDR_W-1:0] rd;
    } mem_wb_t;

    state_t  state_q, state_d;
    logic [1:0] flush_left_q, flush_left_d;
    id_ex_t  dec, id_ex_q;
    ex_mem_t ex_mem_q;
    mem_wb_t mem_wb_q;
    logic    uses_rs2, hazard, flush_now, stall, bubble_ex;

    always_comb begin
        dec      = '0;
        uses_rs2 = 1'b0;
        if (id_valid) begin
            case (opcode)
                OP_R: begin
                    dec.alu_op = ALU_RTYPE; dec.reg_write = 1'b1; dec.rd = rd; uses_rs2 = 1'b1;
                end
                OP_I: begin
                    dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.rd = rd;
                end
                OP_B: begin
                    dec.alu_op = ALU_SUB; dec.branch = 1'b1; dec.rd = rd; uses_rs2 = 1'b1;
                end
                OP_JAL: begin
                    dec.alu_op = ALU_ADD; dec.jump = 1'b1; dec.reg_write = 1'b1; dec.rd = rd;
                end
                OP_LOAD: begin
                    dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_2_reg = 1'b1;
                    dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.rd = rd;
                end
                OP_STORE: begin
                    dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.rd = rd;
                    uses_rs2 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign hazard = id_ex_q.mem_read && (id_ex_q.rd != '0) && id_valid &&
                    ((id_ex_q.rd == rs1) || ((id_ex_q.rd == rs2) && uses_rs2));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            flush_left_q <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        case (state_q)
            ST_RUN: begin
                if (ex_taken && (FLUSH_DEPTH > 1)) begin
                    state_d      = ST_FLUSH;
                    flush_left_d = FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                flush_left_d = flush_left_q - 2'd1;
                if (flush_left_q == 2'd1) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Reset forces the idle control values even before the registers have cleared.
    always_comb begin
        flush_now   = !rst && (ex_taken || (state_q == ST_FLUSH));
        stall       = !rst && hazard && !flush_now;
        bubble_ex   = stall || flush_now;
        pc_write    = !stall;
        if_id_write = !stall;
        if_id_flush = flush_now;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= bubble_ex ? '0 : dec;
            ex_mem_q <= {id_ex_q.mem_read, id_ex_q.mem_write, id_ex_q.mem_2_reg,
                         id_ex_q.reg_write, id_ex_q.rd};
            mem_wb_q <= {ex_mem_q.mem_2_reg, ex_mem_q.reg_write, ex_mem_q.rd};
        end
    end

    assign ex_alu_op    = id_ex_q.alu_op;
    assign ex_alu_src   = id_ex_q.alu_src;
    assign ex_branch    = id_ex_q.branch;
    assign ex_jump      = id_ex_q.jump;
    assign ex_rd        = id_ex_q.rd;
    assign mem_read     = ex_mem_q.mem_read;
    assign mem_write    = ex_mem_q.mem_write;
    assign mem_rd       = ex_mem_q.rd;
    assign wb_mem_2_reg = mem_wb_q.mem_2_reg;
    assign wb_reg_write = mem_wb_q.reg_write;
    assign wb_rd        = mem_wb_q.rd;

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall)     stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_now) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit (FLUSH_DEPTH=2): directed stimulus pushes expected values,
// a negedge monitor pops and compares them.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_B = 7'b1100011;
    localparam logic [6:0] OP_J = 7'b1101111, OP_L = 7'b0000011, OP_S = 7'b0100011;

    // {alu_op, alu_src, branch, jump}
    localparam logic [31:0] EX_R = 32'b10000, EX_I = 32'b00100, EX_B = 32'b01010, EX_J = 32'b00001;

`ifdef PIPE_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam int S_PCW = 0, S_IFW = 1, S_FLUSH = 2, S_EXCTL = 3, S_EXRD = 4, S_MEMCTL = 5;
    localparam int S_MEMRD = 6, S_WBCTL = 7, S_WBRD = 8, S_STALLC = 9, S_FLUSHC = 10;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic        clk = 1'b0;
    logic        rst, id_valid, ex_taken;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic        pc_write, if_id_write, if_id_flush;
    logic [1:0]  ex_alu_op;
    logic        ex_alu_src, ex_branch, ex_jump, mem_read, mem_write, wb_mem_2_reg, wb_reg_write;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_ADDR_W(5), .ALU_OP_W(2), .FLUSH_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
        .ex_taken(ex_taken), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_rd(ex_rd), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rd(mem_rd), .wb_mem_2_reg(wb_mem_2_reg),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_PCW:    return {31'd0, pc_write};
            S_IFW:    return {31'd0, if_id_write};
            S_FLUSH:  return {31'd0, if_id_flush};
            S_EXCTL:  return {27'd0, ex_alu_op, ex_alu_src, ex_branch, ex_jump};
            S_EXRD:   return {27'd0, ex_rd};
            S_MEMCTL: return {30'd0, mem_read, mem_write};
            S_MEMRD:  return {27'd0, mem_rd};
            S_WBCTL:  return {30'd0, wb_mem_2_reg, wb_reg_write};
            S_WBRD:   return {27'd0, wb_rd};
            S_STALLC: return stall_cnt;
            S_FLUSHC: return flush_cnt;
            default:  return 32'hdead_beef;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        chk_t c;
        logic [31:0] act;
        while (sb.size() > 0) begin
            c   = sb.pop_front();
            act = actual(c.sel);
            vectors++;
            if (act !== c.exp) begin
                miscompares++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", c.name, act, c.exp);
            end
        end
    end

    task automatic cyc(input logic v, input logic [6:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic tk, input logic r);
        @(posedge clk);
        #1;
        id_valid = v; opcode = op; rs1 = a; rs2 = b; rd = d; ex_taken = tk; rst = r;
    endtask

    task automatic idle();
        cyc(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic expect_val(input string n, input int s, input logic [31:0] e);
        chk_t c;
        c.name = n; c.sel = s; c.exp = e;
        sb.push_back(c);
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; opcode = '0; rs1 = '0; rs2 = '0; rd = '0; ex_taken = 1'b1;

        // reset held with ex_taken high
        cyc(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        expect_val("rst_pcw", S_PCW, 1);
        expect_val("rst_ifw", S_IFW, 1);
        expect_val("rst_flush", S_FLUSH, 0);
        expect_val("rst_exctl", S_EXCTL, 0);
        expect_val("rst_memctl", S_MEMCTL, 0);
        expect_val("rst_wbctl", S_WBCTL, 0);
        expect_val("rst_stallc", S_STALLC, 0);
        expect_val("rst_flushc", S_FLUSHC, 0);

        // load-use on rs1
        cyc(1'b1, OP_L, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
        expect_val("lu_pre_pcw", S_PCW, 1);
        cyc(1'b1, OP_R, 5'd5, 5'd3, 5'd6, 1'b0, 1'b0);
        expect_val("lu_ex_load", S_EXCTL, EX_I);
        expect_val("lu_ex_rd", S_EXRD, 5);
        expect_val("lu_pcw", S_PCW, 0);
        expect_val("lu_ifw", S_IFW, 0);
        cyc(1'b1, OP_R, 5'd5, 5'd3, 5'd6, 1'b0, 1'b0);
        expect_val("lu_bubble_ex", S_EXCTL, 0);
        expect_val("lu_bubble_rd", S_EXRD, 0);
        expect_val("lu_mem_load", S_MEMCTL, 2'b10);
        expect_val("lu_mem_rd", S_MEMRD, 5);
        expect_val("lu_pcw_after", S_PCW, 1);
        expect_val("lu_stallc", S_STALLC, PERF ? 32'd1 : 32'd0);
        idle();
        expect_val("lu_r_late_ex", S_EXCTL, EX_R);
        expect_val("lu_r_late_rd", S_EXRD, 6);
        expect_val("lu_wb_load", S_WBCTL, 2'b11);
        expect_val("lu_wb_rd", S_WBRD, 5);

        // load to x0: no stall
        cyc(1'b1, OP_L, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, OP_R, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
        expect_val("x0_pcw", S_PCW, 1);
        expect_val("x0_ifw", S_IFW, 1);
        idle();
        expect_val("x0_r_ex", S_EXCTL, EX_R);

        // I-ALU rs2 field matches: no stall
        cyc(1'b1, OP_L, 5'd2, 5'd2, 5'd7, 1'b0, 1'b0);
        cyc(1'b1, OP_I, 5'd1, 5'd7, 5'd8, 1'b0, 1'b0);
        expect_val("irs2_pcw", S_PCW, 1);
        idle();
        expect_val("irs2_i_ex", S_EXCTL, EX_I);
        expect_val("irs2_i_rd", S_EXRD, 8);

        // STORE rs2 matches: stall
        cyc(1'b1, OP_L, 5'd2, 5'd2, 5'd7, 1'b0, 1'b0);
        cyc(1'b1, OP_S, 5'd1, 5'd7, 5'd0, 1'b0, 1'b0);
        expect_val("srs2_pcw", S_PCW, 0);
        cyc(1'b1, OP_S, 5'd1, 5'd7, 5'd0, 1'b0, 1'b0);
        expect_val("srs2_pcw_after", S_PCW, 1);
        expect_val("srs2_bubble", S_EXCTL, 0);
        expect_val("srs2_stallc", S_STALLC, PERF ? 32'd2 : 32'd0);
        idle();
        expect_val("srs2_st_ex", S_EXCTL, EX_I);
        idle();
        expect_val("srs2_st_mem", S_MEMCTL, 2'b01);

        // taken branch, two bubbles; ex_taken during FLUSH ignored
        cyc(1'b1, OP_B, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
        cyc(1'b1, OP_R, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);
        expect_val("br_ex", S_EXCTL, EX_B);
        expect_val("br_flush0", S_FLUSH, 1);
        expect_val("br_pcw", S_PCW, 1);
        expect_val("br_flushc0", S_FLUSHC, 0);
        cyc(1'b1, OP_I, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0);
        expect_val("br_flush1", S_FLUSH, 1);
        expect_val("br_bubble1", S_EXCTL, 0);
        expect_val("br_flushc1", S_FLUSHC, PERF ? 32'd1 : 32'd0);
        cyc(1'b1, OP_R, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0);
        expect_val("br_flush_end", S_FLUSH, 0);
        expect_val("br_bubble2", S_EXCTL, 0);
        expect_val("br_bubble2_rd", S_EXRD, 0);
        expect_val("br_flushc2", S_FLUSHC, PERF ? 32'd2 : 32'd0);
        idle();
        expect_val("br_resume_ex", S_EXCTL, EX_R);
        expect_val("br_resume_rd", S_EXRD, 11);

        // taken branch coincides with load-use: flush wins
        cyc(1'b1, OP_L, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
        cyc(1'b1, OP_R, 5'd5, 5'd3, 5'd6, 1'b1, 1'b0);
        expect_val("both_flush", S_FLUSH, 1);
        expect_val("both_pcw", S_PCW, 1);
        expect_val("both_ifw", S_IFW, 1);
        idle();
        expect_val("both_flush2", S_FLUSH, 1);
        expect_val("both_bubble", S_EXCTL, 0);
        expect_val("both_stallc", S_STALLC, PERF ? 32'd2 : 32'd0);
        idle();
        expect_val("both_flush_end", S_FLUSH, 0);
        expect_val("both_flushc", S_FLUSHC, PERF ? 32'd4 : 32'd0);

        // stream R, I, LOAD, STORE, JAL
        cyc(1'b1, OP_R, 5'd1, 5'd2, 5'd13, 1'b0, 1'b0);
        cyc(1'b1, OP_I, 5'd1, 5'd2, 5'd14, 1'b0, 1'b0);
        cyc(1'b1, OP_L, 5'd1, 5'd2, 5'd12, 1'b0, 1'b0);
        cyc(1'b1, OP_S, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0);
        expect_val("st_pcw", S_PCW, 1);
        expect_val("st_wb_r", S_WBCTL, 2'b01);
        expect_val("st_wb_r_rd", S_WBRD, 13);
        cyc(1'b1, OP_J, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
        expect_val("st_wb_i", S_WBCTL, 2'b01);
        expect_val("st_mem_ld", S_MEMCTL, 2'b10);
        expect_val("st_mem_ld_rd", S_MEMRD, 12);
        idle();
        expect_val("st_ex_jal", S_EXCTL, EX_J);
        expect_val("st_ex_jal_rd", S_EXRD, 1);
        expect_val("st_wb_ld", S_WBCTL, 2'b11);
        expect_val("st_mem_st", S_MEMCTL, 2'b01);
        idle();
        expect_val("st_wb_st", S_WBCTL, 2'b00);
        expect_val("st_mem_jal", S_MEMCTL, 2'b00);
        idle();
        expect_val("st_wb_jal", S_WBCTL, 2'b01);
        expect_val("st_wb_jal_rd", S_WBRD, 1);

        // reset mid-stream, during a stall and a taken branch
        cyc(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        cyc(1'b1, OP_L, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
        cyc(1'b1, OP_R, 5'd5, 5'd3, 5'd6, 1'b1, 1'b1);
        expect_val("mrst_pcw", S_PCW, 1);
        expect_val("mrst_ifw", S_IFW, 1);
        expect_val("mrst_flush", S_FLUSH, 0);
        idle();
        expect_val("mrst_exctl", S_EXCTL, 0);
        expect_val("mrst_exrd", S_EXRD, 0);
        expect_val("mrst_memctl", S_MEMCTL, 0);
        expect_val("mrst_memrd", S_MEMRD, 0);
        expect_val("mrst_wbctl", S_WBCTL, 0);
        expect_val("mrst_wbrd", S_WBRD, 0);
        expect_val("mrst_stallc", S_STALLC, 0);
        expect_val("mrst_flushc", S_FLUSHC, 0);
        expect_val("mrst_flush_after", S_FLUSH, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle RISC-V control decoder.
- Decodes the ID-stage opcode into a control word and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and stalls for them.
- Inserts a parameterisable number of bubbles after a taken branch or jump resolved in EX.
- Sits between the IF/ID register and the datapath stage registers of the 5-stage core.

Parameters:
REG_ADDR_W, 5, register-index width (rs1/rs2/rd).
ALU_OP_W, 2, width of the ALUOp field; codes used are ADD=0, SUB=1, RTYPE=2, zero-extended to ALU_OP_W.
FLUSH_DEPTH, 1, bubbles inserted per taken branch/jump; legal range 1..3.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
id_valid  in  1  IF/ID holds a real instruction
opcode  in  7  ID-stage opcode[6:0]
rs1  in  REG_ADDR_W  ID-stage source 1
rs2  in  REG_ADDR_W  ID-stage source 2
rd  in  REG_ADDR_W  ID-stage destination
ex_taken  in  1  branch/jump in EX is taken (from EX comparator)
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID update enable
if_id_flush  out  1  clear IF/ID to bubble
ex_alu_op  out  ALU_OP_W  EX-stage ALUOp
ex_alu_src  out  1  EX: immediate operand select
ex_branch  out  1  EX: instruction is a branch
ex_jump  out  1  EX: instruction is a jump
ex_rd  out  REG_ADDR_W  EX destination (for forwarding)
mem_read  out  1  MEM: load
mem_write  out  1  MEM: store
mem_rd  out  REG_ADDR_W  MEM destination
wb_mem_2_reg  out  1  WB: select memory data
wb_reg_write  out  1  WB: register-file write enable
wb_rd  out  REG_ADDR_W  WB destination
stall_cnt  out  32  load-use stall cycles (see optional feature)
flush_cnt  out  32  flush cycles (see optional feature)

Behaviour:
- Decode table (combinational, fields alu_src/mem_2_reg/reg_write/mem_read/mem_write/branch/jump/alu_op):
  - R-type 0110011: 0/0/1/0/0/0/0/RTYPE
  - I-ALU 0010011: 1/0/1/0/0/0/0/ADD
  - BRANCH 1100011: 0/0/0/0/0/1/0/SUB
  - JAL 1101111: 0/0/1/0/0/0/1/ADD (rd=PC+4)
  - LOAD 0000011: 1/1/1/1/0/0/0/ADD
  - STORE 0100011: 1/0/0/0/1/0/0/ADD
  - Other opcodes, or id_valid=0: bubble (all zero).
- Bubble definition: all control bits zero and rd field zero. A bubble never writes registers or memory.
- Latency: ex_* outputs are the decoded word 1 cycle after ID; mem_* after 2 cycles; wb_* after 3 cycles.
- EX/MEM and MEM/WB registers advance unconditionally every cycle.
- Load-use hazard (combinational):
  - hazard = mem_read_ex & ex_rd != 0 & (ex_rd == rs1 | (ex_rd == rs2 & opcode in {R, BRANCH, STORE})) & id_valid.
  - On hazard: pc_write=0, if_id_write=0, ID/EX loads a bubble. Exactly one stall cycle per hazard.
- FSM states: RUN, FLUSH.
  - RUN & ex_taken: if_id_flush=1, ID/EX loads a bubble, pc_write=1.
    - FLUSH_DEPTH=1: remain in RUN.
    - Otherwise: go to FLUSH with remaining count = FLUSH_DEPTH-1.
  - FLUSH: if_id_flush=1 and ID/EX loads a bubble each cycle; count decrements; at zero, go to RUN.
  - ex_taken is ignored while in FLUSH, because EX holds a bubble.
- Simultaneous ex_taken and hazard: the flush wins. Stall is suppressed: pc_write=1, if_id_write=1.
- Reset:
  - All stage registers become bubbles and the FSM enters RUN.
  - pc_write=1, if_id_write=1, if_id_flush=0.
  - Both counters clear to 0.
- Reset asserted mid-flush or mid-stall aborts it on the next edge.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined: stall_cnt increments on each hazard-stall cycle; flush_cnt increments on each cycle with if_id_flush=1. Both wrap at 2^32 and clear on rst.
- Undefined: no counter flops; both outputs tied to 0.

Test Plan:
- LOAD rd=5, then R-type rs1=5 -> 1 stall cycle. pc_write=0 and if_id_write=0 for 1 cycle; ex_* is a bubble; the R-type reaches EX one cycle late. stall_cnt=1 with macro.
- LOAD rd=0, then R-type rs1=0 -> no stall.
- LOAD rd=7, then I-ALU with rs2 field=7 -> no stall (rs2 unused).
- BRANCH with ex_taken=1, FLUSH_DEPTH=2 -> if_id_flush=1 for 2 cycles and 2 bubbles in EX. flush_cnt=2 with macro, 0 without.
- ex_taken=1 in the same cycle as a load-use hazard -> if_id_flush=1, pc_write=1, stall_cnt unchanged.
- Stream R, I, LOAD, STORE, JAL -> wb_reg_write sequence 1,1,1,0,1; mem_write asserted exactly at the STORE's MEM cycle. Then rst mid-stream -> all ex/mem/wb outputs 0 the next cycle.
